// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (8N1) feeding a small FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to build the 8E1 variant with even-parity checking.
module uart_rx_fifo #(
  parameter int DIV        = 868,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] d_rx,
  output logic       vld_rx,
  input  logic       rdy_rx,
  output logic       frm_err,
  output logic       par_err,
  output logic       ovf,
  output logic       busy
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [11:0]         HALF_LAST = 12'(DIV / 2 - 1);
  localparam logic [11:0]         BIT_LAST  = 12'(DIV - 1);
  localparam logic [11:0]         CNT_ONE   = 12'd1;
  localparam logic [2:0]          IDX_ONE   = 3'd1;
  localparam logic [DEPTH_LOG2:0] PTR_ONE   = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PAR   = 3'd3,
`endif
    STOP  = 3'd4
  } state_t;

  state_t state, next;

  logic sync1, rxs, rxs_d;
  logic fall, half_tick, bit_tick;
  logic [11:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic par_pend;
  logic byte_done, frm_hit, par_hit;

  logic [7:0] mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic full, empty, pop, push, drop;

  // The line is asynchronous: two flops for metastability, a third for edge history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign fall      = rxs_d & ~rxs;
  assign half_tick = (cnt == HALF_LAST);
  assign bit_tick  = (cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (fall) next = START;
      // A start bit that is high again at mid-bit was only a glitch.
      START: if (half_tick) next = rxs ? IDLE : DATA;
      DATA: begin
        if (bit_tick && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          next = PAR;
`else
          next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR:   if (bit_tick) next = STOP;
`endif
      STOP:  if (bit_tick) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Framing takes priority over parity when both checks fail on the same frame.
  always_comb begin
    busy      = (state != IDLE);
    byte_done = 1'b0;
    frm_hit   = 1'b0;
    par_hit   = 1'b0;
    if (state == STOP && bit_tick) begin
      if (!rxs)          frm_hit   = 1'b1;
      else if (par_pend) par_hit   = 1'b1;
      else               byte_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: cnt <= '0;
        START: begin
          if (half_tick) begin
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + IDX_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: cnt <= bit_tick ? 12'd0 : cnt + CNT_ONE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                        par_pend <= 1'b0;
    else if (state == START)          par_pend <= 1'b0;
    else if (state == PAR && bit_tick) par_pend <= ^shreg ^ rxs;
  end
`else
  assign par_pend = 1'b0;
`endif

  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && rdy_rx;
  // On a full FIFO a same-cycle pop frees the head slot, which the push then reuses.
  assign push  = byte_done && (!full || pop);
  assign drop  = byte_done && full && !pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= shreg;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign d_rx   = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign vld_rx = !empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frm_err <= 1'b0;
      par_err <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      frm_err <= frm_hit;
      par_err <= par_hit;
      ovf     <= drop;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the debug control panel: it deserialises 8N1 UART frames from the host line and buffers the bytes in a 4-entry FIFO. Bytes are presented to the panel's scan stage on the `d_rx`/`vld_rx`/`rdy_rx` handshake, and the block also reports framing, parity and overflow events. It sits between the board RX pin and the panel, in the `clk` domain.

## Interface
- `DIV`, default 868: clock cycles per bit (100 MHz / 115200). Legal range is 4..4095, and `DIV` must be even.
- `DEPTH_LOG2`, default 2: log2 of the FIFO depth. The default gives 4 entries.

- `clk`  in  1  System clock; all logic is on the rising edge.
- `rstn`  in  1  Reset, asynchronous and active-low.
- `rxd`  in  1  Raw serial line, asynchronous to `clk`; idles high.
- `d_rx`  out  8  Byte at the FIFO head. Valid only while `vld_rx` is high.
- `vld_rx`  out  1  FIFO non-empty.
- `rdy_rx`  in  1  Consumer ready. The FIFO pops in any cycle where `vld_rx && rdy_rx`.
- `frm_err`  out  1  One-cycle pulse when a stop bit is sampled low.
- `par_err`  out  1  One-cycle pulse on a parity mismatch. Tied to 0 when parity is compiled out.
- `ovf`  out  1  One-cycle pulse when a good byte is dropped because the FIFO is full.
- `busy`  out  1  High whenever the receiver FSM is not in IDLE.

## Operation
- **Synchroniser.** `rxd` passes through 2 flops to give `rxs`, plus 1 history flop `rxs_d`. All three reset to 1.
- **FSM states:** IDLE, START, DATA, PAR (parity builds only), STOP. Registers: `cnt` is 12 bits, `bit_idx` is 3 bits, `shreg` is 8 bits.
- **IDLE.** A falling edge (`rxs_d==1 && rxs==0`) moves to START with `cnt<=0`. A line held low does not retrigger.
- **START.**
  - `cnt` increments each cycle.
  - At `cnt==DIV/2-1` the FSM samples `rxs`.
  - If the sample is 0, it moves to DATA with `cnt<=0` and `bit_idx<=0`.
  - If the sample is 1, the event is treated as a glitch and the FSM returns to IDLE with no flag.
- **DATA.**
  - At `cnt==DIV-1` the FSM samples `rxs` into `shreg` as `{rxs, shreg[7:1]}`, so data arrives LSB first. It then sets `cnt<=0` and increments `bit_idx`.
  - After the sample at `bit_idx==7`, it moves to STOP, or to PAR in parity builds.
- **STOP.** At `cnt==DIV-1` the FSM samples `rxs` and returns to IDLE.
  - If the sample is 1 and no parity error is pending, `shreg` is pushed.
  - If the sample is 0, `frm_err` pulses and the byte is discarded.
  - If both the framing and parity checks fail, only `frm_err` pulses.
- **FIFO.** Circular buffer with (`DEPTH_LOG2`+1)-bit read and write pointers. Full means the MSBs differ and the low bits are equal; empty means the pointers are equal. `d_rx` is a combinational read of the head entry.
- **Push when full and no pop in the same cycle:** the byte is dropped and `ovf` pulses.
- **Push when full with a pop in the same cycle:** the push is accepted and the occupancy stays at full.
- **Push when empty:** the byte is visible on the next cycle.
- **Pointer wrap-around** is modulo 2^(`DEPTH_LOG2`+1).
- **Reset mid-frame** aborts the frame. State returns to IDLE, the FIFO empties, and all pulses go to 0.

## Timing
- **Reset values:** `vld_rx`=0, `d_rx`=0 (storage is cleared), `frm_err`=`par_err`=`ovf`=0, `busy`=0.
- **Detect latency:** IDLE→START happens 3 cycles after the pin edge (2 synchroniser cycles plus 1 edge-detect cycle).
- **Sample points:** mid-bit. Bit k (0 = start) is sampled `DIV/2 + k*DIV` cycles after START entry.
- **Output latency:** `vld_rx` rises on the cycle after the stop-bit sample. `frm_err`, `par_err` and `ovf` assert on that same cycle.
- **Pop timing:** a pop takes effect at the clock edge. `d_rx` shows the next entry on the following cycle.
- **Busy timing:** `busy` falls on the cycle the FSM re-enters IDLE. Back-to-back frames with zero idle time are received.
- **Handshake rule:** `d_rx` is held stable while `vld_rx && !rdy_rx`.

## Configuration
- `UART_RX_PARITY_EN` defined: frames are 8E1.
  - The PAR state samples a bit at `cnt==DIV-1`.
  - A mismatch against even parity (`^shreg ^ sample != 0`) sets a pending error.
  - In STOP, a pending error causes the byte to be discarded and `par_err` to pulse.
- `UART_RX_PARITY_EN` undefined: frames are 8N1, there is no PAR state, and `par_err` is constant 0.

## Test plan
- **Single byte:** `DIV`=16, `rdy_rx`=1, send 0x44 on `rxd` → `vld_rx` high for exactly 1 cycle with `d_rx`=0x44, and no error pulses.
- **Glitch rejection:** `rxd` driven low for 4 cycles then high → `busy` pulses and returns low, with no `vld_rx` and no flags.
- **Framing error:** 0x52 sent with its stop bit low → one `frm_err` pulse, `vld_rx` stays 0, and a following 0x50 is received correctly.
- **Overflow and ordering:** `rdy_rx`=0, send 0x01..0x05 back-to-back → `ovf` pulses once at the 5th stop sample. Raising `rdy_rx` then drains 0x01, 0x02, 0x03, 0x04 in order, and `vld_rx` falls after 0x04.
- **Pop and push on a full FIFO:** with the FIFO full, pop on the same cycle as a push of 0x06 → no `ovf`, and the drain ends with 0x06.
- **Reset mid-frame:** assert `rstn`=0 during DATA with 2 bytes queued → all outputs 0 and the FIFO empty. The next frame, 0x47, is received normally.
- **Parity, `UART_RX_PARITY_EN` defined:** 0x03 sent with parity bit 1 → `par_err` pulse and no byte. Sent with parity bit 0 → 0x03 delivered.
